// File: rtl/ripple_carry_adder_4_pkg.sv
// Shared definitions for the registered ripple-carry adder/subtractor.
//   WIDTH_DEFAULT : default operand width (result is WIDTH+1 bits)
//   CTRL_ADD/SUB  : encodings of the mode control bit
package ripple_carry_adder_4_pkg;

  localparam int WIDTH_DEFAULT = 4;

  localparam logic CTRL_ADD = 1'b0;
  localparam logic CTRL_SUB = 1'b1;

endpackage

// File: rtl/ripple_carry_adder_4_full_adder.sv
// Single-bit full adder, purely combinational. One stage of the carry chain.
//   a, b : operand bits
//   cin  : carry from the previous stage
//   s    : sum bit
//   cout : carry into the next stage
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  // p is the propagate term; the carry-out is generate OR propagate-with-carry.
  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder_4.sv
// Registered ripple-carry adder/subtractor.
// In subtract mode B is inverted and the carry-in is forced to 1, so the
// same chain computes A + ~B + 1 = A - B. The carry-out then means
// "no borrow" (A >= B); it is not a sign bit.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears S
//   A, B : operands
//   CTRL : CTRL_ADD (A+B) or CTRL_SUB (A-B)
//   S    : registered {carry-out, sum}, valid one cycle after the inputs
module ripple_carry_adder_4
  import ripple_carry_adder_4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CTRL,
  output logic [WIDTH:0]   S
);

  logic             sub_mode;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign sub_mode = (CTRL == CTRL_SUB);
  assign bx       = B ^ {WIDTH{sub_mode}};
  assign c[0]     = sub_mode;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a    (A[i]),
      .b    (bx[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      S <= '0;
    end else begin
      S <= {c[WIDTH], sum};
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder_4.sv
// Testbench for ripple_carry_adder_4: directed table, hand-written
// multi-cycle sequences, exhaustive sweep and random back-to-back stimulus,
// all checked against an arithmetic reference model.
module tb_ripple_carry_adder_4;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       CTRL;
  logic [4:0] S;

  int passed = 0;
  int total  = 0;

  ripple_carry_adder_4 dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .CTRL (CTRL),
    .S    (S)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Add: plain unsigned sum. Subtract: difference mod 16 with a no-borrow flag.
  function automatic logic [4:0] ref_model(input logic r, input logic [3:0] a,
                                           input logic [3:0] b, input logic ctrl);
    int d;
    if (r) return 5'd0;
    if (!ctrl) return 5'(int'(a) + int'(b));
    d = int'(a) - int'(b);
    return {(a >= b), 4'((d + 16) % 16)};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: S=%b expected %b", name, act, exp);
  endtask

  // Drive at negedge, let the posedge capture, compare just after it.
  task automatic apply(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic ctrl);
    @(negedge clk);
    rst  = r;
    A    = a;
    B    = b;
    CTRL = ctrl;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      name;
    logic       r;
    logic [3:0] a;
    logic [3:0] b;
    logic       ctrl;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[10];
  logic [4:0] exp_q[$];

  initial begin
    rst = 1'b1; A = '0; B = '0; CTRL = 1'b0;

    tbl[0] = '{"reset",          1'b1, 4'hF,    4'hF,    1'b0, 5'b00000};
    tbl[1] = '{"reset_held",     1'b1, 4'b1001, 4'b0011, 1'b1, 5'b00000};
    tbl[2] = '{"sub_9_3",        1'b0, 4'b1001, 4'b0011, 1'b1, 5'b10110};
    tbl[3] = '{"add_9_3",        1'b0, 4'b1001, 4'b0011, 1'b0, 5'b01100};
    tbl[4] = '{"add_f_f",        1'b0, 4'hF,    4'hF,    1'b0, 5'b11110};
    tbl[5] = '{"sub_3_9_borrow", 1'b0, 4'b0011, 4'b1001, 1'b1, 5'b01010};
    tbl[6] = '{"sub_0_0",        1'b0, 4'h0,    4'h0,    1'b1, 5'b10000};
    tbl[7] = '{"add_0_0",        1'b0, 4'h0,    4'h0,    1'b0, 5'b00000};
    tbl[8] = '{"reset_mid",      1'b1, 4'h7,    4'h8,    1'b0, 5'b00000};
    tbl[9] = '{"sub_f_0",        1'b0, 4'hF,    4'h0,    1'b1, 5'b11111};

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].ctrl);
      check(tbl[i].name, S, tbl[i].exp);
    end

    // S holds between edges; a mid-cycle CTRL change waits for the next edge.
    apply(1'b0, 4'd5, 4'd7, 1'b0);
    check("hold_add", S, 5'd12);
    @(negedge clk);
    CTRL = 1'b1;
    #2;
    check("hold_mid_cycle", S, 5'd12);
    @(posedge clk);
    #1;
    check("ctrl_next_edge", S, 5'b01110);

    // Reset priority over operands, then first non-reset edge loads inputs.
    apply(1'b1, 4'hA, 4'h5, 1'b0);
    check("reset_priority", S, 5'd0);
    apply(1'b0, 4'hA, 4'h5, 1'b0);
    check("reset_release", S, 5'd15);

    // Exhaustive sweep, one operation per cycle.
    for (int k = 0; k < 512; k++) begin
      logic [3:0] a;
      logic [3:0] b;
      logic       ct;
      a  = 4'(k);
      b  = 4'(k >> 4);
      ct = k[8];
      exp_q.push_back(ref_model(1'b0, a, b, ct));
      apply(1'b0, a, b, ct);
      check("exhaustive", S, exp_q.pop_front());
    end

    // Random back-to-back stream with occasional mid-stream resets.
    for (int k = 0; k < 1000; k++) begin
      logic       r;
      logic [3:0] a;
      logic [3:0] b;
      logic       ct;
      r  = ($urandom_range(0, 24) == 0);
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      ct = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_model(r, a, b, ct));
      apply(r, a, b, ct);
      check(r ? "random_reset" : "random", S, exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder_4.md
# ripple_carry_adder_4

Registered 4-bit ripple-carry adder/subtractor for the arithmetic datapath. Operand B is conditionally inverted by a single control bit and fed with that bit as carry-in, so one chain of four full adders computes A+B or A−B. The 5-bit result (carry/no-borrow in bit 4) is captured in an output register on the rising clock edge.

## Interface
- WIDTH, 4, operand width. Only 4 is required to be supported; the result is WIDTH+1 bits.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- A  input  4  operand A, unsigned or two's complement
- B  input  4  operand B
- CTRL  input  1  0 = add (A+B), 1 = subtract (A−B)
- S  output  5  registered result; S[3:0] = sum/difference, S[4] = carry-out
- Port order for positional instantiation: clk, rst, A, B, CTRL, S.

## Operation
- Operand conditioning: Bx[i] = B[i] XOR CTRL for i = 0..3; carry-in c0 = CTRL.
- Four cascaded full adders, stage i: s[i] = A[i]^Bx[i]^c[i]; c[i+1] = A[i]&Bx[i] | c[i]&(A[i]^Bx[i]).
- Next result = {c4, s[3:0]}, i.e. A + (B XOR {4{CTRL}}) + CTRL, taken mod 32.
- Add mode: S = A + B, unsigned, with no loss; range 0..30.
- Subtract mode: S[3:0] = (A − B) mod 16; S[4] = 1 when A ≥ B (no borrow) and 0 when A < B (borrow). S[4] is not a sign bit.
- No overflow flag and no saturation. Signed overflow is left to the consumer.
- Inputs are not registered. Only S is registered.

## Timing
- Reset: when rst = 1 at a rising clk edge, S ← 5'b00000. Reset has priority over new operands. Inputs present during reset are discarded.
- Latency: 1 cycle. Inputs that are stable before rising edge n appear on S after edge n.
- Throughput: one operation per cycle. No handshake and no enable.
- S holds its value between edges. The combinational chain must settle within one clock period, with the critical path being c0 → c4 through 4 stages.
- Deassertion of reset: the first non-reset edge loads the current A, B and CTRL.
- A CTRL change between edges takes effect at the next edge. There is no mode memory.

## Structure
- Sub-module full_adder with ports a, b, cin, s, cout, purely combinational. It is instantiated WIDTH times in a generate loop and chained through cout → cin.
- Top level contains the XOR conditioning, the carry chain wiring and the single 5-bit output register.
- Shared package: WIDTH default (4) and the mode encodings CTRL_ADD = 1'b0 and CTRL_SUB = 1'b1.

## Test plan
- Reset: rst=1, A=4'hF, B=4'hF, CTRL=0 → S=5'b00000 after the edge; stays 0 while rst is held.
- Subtract: A=4'b1001, B=4'b0011, CTRL=1 → S=5'b10110 (difference 6, no borrow) one cycle later.
- Add: A=4'b1001, B=4'b0011, CTRL=0 → S=5'b01100 (12). Also A=4'hF, B=4'hF, CTRL=0 → S=5'b11110 (30, carry-out set).
- Borrow: A=4'b0011, B=4'b1001, CTRL=1 → S=5'b01010 (−6 mod 16 = 10, S[4]=0). Also A=0, B=0, CTRL=1 → S=5'b10000.
- Back-to-back pipeline: apply a different (A, B, CTRL) every cycle, including CTRL toggling → each S matches the reference model for the inputs sampled one edge earlier. Asserting rst mid-stream zeroes S on that edge.
- Exhaustive/random: all 512 combinations of A, B and CTRL (or ≥1000 $random vectors) → S == A + (B ^ {4{CTRL}}) + CTRL mod 32, checked each cycle.
